// File: rtl/acq_seq_pkg.sv
// rtl/acq_seq_pkg.sv - shared types, default widths and reset constants for the acquisition sequencer
package acq_seq_pkg;

    localparam int DELAY_W_DEF   = 16;
    localparam int LEN_W_DEF     = 8;
    localparam int HOLDOFF_W_DEF = 16;
    localparam int CNT_W_DEF     = 16;

    // Active sequencing config after reset: one-cycle window, one-cycle hold-off.
    localparam int RST_TRIG_DELAY = 0;
    localparam int RST_STORE_LEN  = 1;
    localparam int RST_HOLDOFF    = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_DELAY,
        ST_STORE,
        ST_HOLDOFF
    } acq_state_t;

    // Configuration handed to the Timing generator.
    typedef struct packed {
        logic [7:0] b1_strobe;
        logic [7:0] b2_strobe;
        logic [1:0] no_bunches;
        logic [3:0] no_samples;
        logic [7:0] sample_spacing;
    } timing_cfg_t;

endpackage

// File: rtl/acq_cfg_shadow.sv
// rtl/acq_cfg_shadow.sv - shadow/active config register sets with deferred apply
// Ports: clk, rst_n (sync active-low); cfg_wr + cfg_* capture into the shadow set;
// apply_en from the sequencer FSM allows the pending shadow set to become active;
// cfg_ack pulses on the apply edge; act_* are the registered active values.
module acq_cfg_shadow
    import acq_seq_pkg::*;
#(
    parameter int DELAY_W   = DELAY_W_DEF,
    parameter int LEN_W     = LEN_W_DEF,
    parameter int HOLDOFF_W = HOLDOFF_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_wr,
    input  logic [DELAY_W-1:0]   cfg_trig_delay,
    input  logic [LEN_W-1:0]     cfg_store_len,
    input  logic [HOLDOFF_W-1:0] cfg_holdoff,
    input  timing_cfg_t          cfg_timing,
    input  logic                 apply_en,
    output logic                 cfg_ack,
    output logic [DELAY_W-1:0]   act_trig_delay,
    output logic [LEN_W-1:0]     act_store_len,
    output logic [HOLDOFF_W-1:0] act_holdoff,
    output timing_cfg_t          act_timing
);

    logic                 pending;
    logic                 apply;
    logic [DELAY_W-1:0]   sh_trig_delay;
    logic [LEN_W-1:0]     sh_store_len;
    logic [HOLDOFF_W-1:0] sh_holdoff;
    timing_cfg_t          sh_timing;

    assign apply = apply_en & pending;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending        <= 1'b0;
            cfg_ack        <= 1'b0;
            sh_trig_delay  <= DELAY_W'(RST_TRIG_DELAY);
            sh_store_len   <= LEN_W'(RST_STORE_LEN);
            sh_holdoff     <= HOLDOFF_W'(RST_HOLDOFF);
            sh_timing      <= '0;
            act_trig_delay <= DELAY_W'(RST_TRIG_DELAY);
            act_store_len  <= LEN_W'(RST_STORE_LEN);
            act_holdoff    <= HOLDOFF_W'(RST_HOLDOFF);
            act_timing     <= '0;
        end else begin
            cfg_ack <= apply;
            // A write landing on the apply edge keeps the flag set so the newer
            // shadow contents are applied on a later edge.
            if (cfg_wr) begin
                pending       <= 1'b1;
                sh_trig_delay <= cfg_trig_delay;
                sh_store_len  <= cfg_store_len;
                sh_holdoff    <= cfg_holdoff;
                sh_timing     <= cfg_timing;
            end else if (apply) begin
                pending <= 1'b0;
            end
            if (apply) begin
                act_trig_delay <= sh_trig_delay;
                act_store_len  <= sh_store_len;
                act_holdoff    <= sh_holdoff;
                act_timing     <= sh_timing;
            end
        end
    end

endmodule

// File: rtl/acq_sequencer.sv
// rtl/acq_sequencer.sv - trigger-to-store-window sequencer with hold-off and safe config apply
// Ports: clk, rst_n (sync active-low); arm, trig inputs; cfg_wr + cfg_* host config;
// outputs cfg_ack, store_strb, active Timing config, busy, acq_done, acq_count, trig_missed.
// Build option: define ACQ_TRIG_MISSED_CNT_EN to count triggers ignored while busy;
// otherwise trig_missed is tied to 0.
module acq_sequencer
    import acq_seq_pkg::*;
#(
    parameter int DELAY_W   = DELAY_W_DEF,
    parameter int LEN_W     = LEN_W_DEF,
    parameter int HOLDOFF_W = HOLDOFF_W_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 arm,
    input  logic                 trig,
    input  logic                 cfg_wr,
    input  logic [DELAY_W-1:0]   cfg_trig_delay,
    input  logic [LEN_W-1:0]     cfg_store_len,
    input  logic [HOLDOFF_W-1:0] cfg_holdoff,
    input  logic [7:0]           cfg_b1_strobe,
    input  logic [7:0]           cfg_b2_strobe,
    input  logic [1:0]           cfg_no_bunches,
    input  logic [3:0]           cfg_no_samples,
    input  logic [7:0]           cfg_sample_spacing,
    output logic                 cfg_ack,
    output logic                 store_strb,
    output logic [7:0]           b1_strobe,
    output logic [7:0]           b2_strobe,
    output logic [1:0]           no_bunches,
    output logic [3:0]           no_samples,
    output logic [7:0]           sample_spacing,
    output logic                 busy,
    output logic                 acq_done,
    output logic [CNT_W-1:0]     acq_count,
    output logic [CNT_W-1:0]     trig_missed
);

    acq_state_t           state, state_nx;
    logic                 trig_q, trig_rise, accept, apply_en;
    logic                 store_strb_nx, acq_done_nx, busy_nx;
    logic [DELAY_W-1:0]   delay_cnt, act_trig_delay;
    logic [LEN_W-1:0]     len_cnt, act_store_len;
    logic [HOLDOFF_W-1:0] ho_cnt, act_holdoff;
    timing_cfg_t          cfg_timing, act_timing;

    assign trig_rise = trig & ~trig_q;
    assign accept    = (state == ST_ARMED) && arm && trig_rise;
    // Never apply on the edge a trigger is taken: that acquisition must run
    // entirely on the set that was active when it was triggered.
    assign apply_en  = (state == ST_IDLE) || ((state == ST_ARMED) && !accept);

    assign cfg_timing = '{b1_strobe: cfg_b1_strobe, b2_strobe: cfg_b2_strobe,
                          no_bunches: cfg_no_bunches, no_samples: cfg_no_samples,
                          sample_spacing: cfg_sample_spacing};

    acq_cfg_shadow #(.DELAY_W(DELAY_W), .LEN_W(LEN_W), .HOLDOFF_W(HOLDOFF_W)) u_cfg (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_wr         (cfg_wr),
        .cfg_trig_delay (cfg_trig_delay),
        .cfg_store_len  (cfg_store_len),
        .cfg_holdoff    (cfg_holdoff),
        .cfg_timing     (cfg_timing),
        .apply_en       (apply_en),
        .cfg_ack        (cfg_ack),
        .act_trig_delay (act_trig_delay),
        .act_store_len  (act_store_len),
        .act_holdoff    (act_holdoff),
        .act_timing     (act_timing)
    );

    assign b1_strobe      = act_timing.b1_strobe;
    assign b2_strobe      = act_timing.b2_strobe;
    assign no_bunches     = act_timing.no_bunches;
    assign no_samples     = act_timing.no_samples;
    assign sample_spacing = act_timing.sample_spacing;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (arm) state_nx = ST_ARMED;
            ST_ARMED: begin
                if (!arm)           state_nx = ST_IDLE;
                else if (trig_rise) state_nx = (act_trig_delay == '0) ? ST_STORE : ST_DELAY;
            end
            ST_DELAY:   if (delay_cnt == DELAY_W'(1)) state_nx = ST_STORE;
            ST_STORE:   if (len_cnt == '0) state_nx = ST_HOLDOFF;
            ST_HOLDOFF: if (ho_cnt == HOLDOFF_W'(1)) state_nx = arm ? ST_ARMED : ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // STORE spends one extra cycle with len_cnt at 0: that is the exit cycle
    // where the strobe drops and acq_done fires.
    always_comb begin
        store_strb_nx = 1'b0;
        acq_done_nx   = 1'b0;
        busy_nx       = 1'b0;
        if (state == ST_STORE) begin
            store_strb_nx = (len_cnt != '0);
            acq_done_nx   = (len_cnt == '0);
        end
        if (state_nx == ST_DELAY || state_nx == ST_STORE || state_nx == ST_HOLDOFF)
            busy_nx = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trig_q     <= 1'b0;
            store_strb <= 1'b0;
            acq_done   <= 1'b0;
            busy       <= 1'b0;
            acq_count  <= '0;
            delay_cnt  <= '0;
            len_cnt    <= '0;
            ho_cnt     <= '0;
        end else begin
            trig_q     <= trig;
            store_strb <= store_strb_nx;
            acq_done   <= acq_done_nx;
            busy       <= busy_nx;
            if (acq_done_nx && acq_count != '1)
                acq_count <= acq_count + CNT_W'(1);
            if (accept)
                delay_cnt <= act_trig_delay;
            else if (state == ST_DELAY)
                delay_cnt <= delay_cnt - DELAY_W'(1);
            if (state_nx == ST_STORE && state != ST_STORE)
                len_cnt <= (act_store_len == '0) ? LEN_W'(1) : act_store_len;
            else if (state == ST_STORE && len_cnt != '0)
                len_cnt <= len_cnt - LEN_W'(1);
            if (state == ST_STORE && state_nx == ST_HOLDOFF)
                ho_cnt <= (act_holdoff == '0) ? HOLDOFF_W'(1) : act_holdoff;
            else if (state == ST_HOLDOFF)
                ho_cnt <= ho_cnt - HOLDOFF_W'(1);
        end
    end

`ifdef ACQ_TRIG_MISSED_CNT_EN
    logic missed_ev;
    assign missed_ev = trig_rise &&
                       (state == ST_DELAY || state == ST_STORE || state == ST_HOLDOFF);

    always_ff @(posedge clk) begin
        if (!rst_n)
            trig_missed <= '0;
        else if (missed_ev && trig_missed != '1)
            trig_missed <= trig_missed + CNT_W'(1);
    end
`else
    assign trig_missed = '0;
`endif

endmodule
